// File: rtl/result_stream_out_pkg.sv
// Shared definitions for the result streaming block: default widths, FSM states,
// SRAM read latency.
package result_stream_out_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 32;
    // Read data appears this many cycles after the address is presented.
    localparam int unsigned SRAM_RD_LAT = 1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage. Occupancy is unchanged by a simultaneous
// push and pop. The head is read straight from storage, so it holds while not popped.
module sync_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 32,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CntW'(Depth));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/result_stream_out.sv
// Drains a block of result words from SRAM onto a valid/ready stream, with optional
// ReLU clamping. Reads are credit-limited so returning data always fits in the buffer.
module result_stream_out
    import result_stream_out_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W-1:0] result_base_address,
    input  logic [15:0]       result_count,
    input  logic              relu_enable,
    output logic [ADDR_W-1:0] dut__tb__sram_result_read_address,
    input  logic [DATA_W-1:0] tb__dut__sram_result_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       issued_q, issued_d;
    logic [15:0]       beats_q, beats_d;
    logic              relu_q, relu_d;
    logic              inflight_q, inflight_d;

    logic              issue, pop;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic [CntW:0]     occ_after;
    logic [DATA_W-1:0] push_data;

    // Issue/pop decisions and stream outputs.
    always_comb begin
        out_valid = !fifo_empty;
        pop       = out_valid && out_ready;
        // Buffer slots already claimed once this cycle's pop retires.
        occ_after = {1'b0, fifo_count} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
        issue     = (state_q == StFetch) && (issued_q != count_q) &&
                    (occ_after < (CntW + 1)'(FIFO_DEPTH)) && !(fifo_full && !pop);
        push_data = (relu_q && tb__dut__sram_result_read_data[DATA_W-1]) ?
                    '0 : tb__dut__sram_result_read_data;
        out_last  = out_valid && (beats_q == count_q - 16'd1);
    end

    // FSM and job-counter next state.
    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        count_d    = count_q;
        issued_d   = issued_q;
        beats_d    = beats_q;
        relu_d     = relu_q;
        inflight_d = issue;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    rd_addr_d = result_base_address;
                    count_d   = result_count;
                    relu_d    = relu_enable;
                    issued_d  = '0;
                    beats_d   = '0;
                    state_d   = (result_count == 16'd0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (issue) begin
                    issued_d = issued_q + 16'd1;
                    // Address stays on the last word read once the job is fully issued.
                    if (issued_q + 16'd1 != count_q) begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && out_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (pop) begin
            beats_d = beats_q + 16'd1;
        end
    end

    // State registers; reset aborts any job in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            beats_q    <= '0;
            relu_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            beats_q    <= beats_d;
            relu_q     <= relu_d;
            inflight_q <= inflight_d;
        end
    end

    assign start_ready                       = (state_q == StIdle);
    assign done                              = (state_q == StDone);
    assign dut__tb__sram_result_read_address = rd_addr_q;

    sync_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (out_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule
